// File: rtl/hwpe_stream_package.sv
// Shared constants for the HWPE stream / TCDM blocks.
package hwpe_stream_package;

   localparam int unsigned HWPE_STREAM_TCDM_RESP_MAX_LATENCY = 4;
   localparam int unsigned HWPE_STREAM_TCDM_DW               = 32;

   function automatic bit hwpe_stream_is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_responder_if.sv
// TCDM request/response bundle: master = streamer side, slave = memory side.
interface hwpe_stream_tcdm_responder_if #(
   parameter int unsigned DW = 32
) ();

   logic              req;
   logic              gnt;
   logic [31:0]       add;
   logic              wen;
   logic [DW/8-1:0]   be;
   logic [DW-1:0]     data;
   logic [DW-1:0]     r_data;
   logic              r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );

endinterface

// File: rtl/hwpe_stream_tcdm_resp_delay.sv
// Fixed-latency {valid, data} shift line carrying TCDM responses.
module hwpe_stream_tcdm_resp_delay
   import hwpe_stream_package::*;
#(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned DW      = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic          busy_o
);

   if (LATENCY < 1 || LATENCY > HWPE_STREAM_TCDM_RESP_MAX_LATENCY) begin : g_bad_latency
      $error("hwpe_stream_tcdm_resp_delay: LATENCY out of range 1..4");
   end

   logic [LATENCY-1:0] r_valid;
   logic [DW-1:0]      r_data [LATENCY];

   // Shift valid/data one stage per cycle; reset or clear drops everything in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_valid <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_valid[0] <= valid_i;
         r_data[0]  <= data_i;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
         end
      end
   end

   assign valid_o = r_valid[LATENCY-1];
   assign data_o  = r_data[LATENCY-1];
   assign busy_o  = |r_valid;

endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// Single-bank TCDM responder: word array with byte-enabled writes, optional
// periodic grant stall, and fixed-latency in-order responses.
module hwpe_stream_tcdm_responder
   import hwpe_stream_package::*;
#(
   parameter int unsigned NB_WORDS     = 1024,
   parameter int unsigned DW           = 32,
   parameter int unsigned LATENCY      = 1,
   parameter int unsigned STALL_PERIOD = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clear_i,
   hwpe_stream_tcdm_responder_if.slave   tcdm,
   output logic                          busy_o
);

   localparam int unsigned AW = $clog2(NB_WORDS);
   localparam int unsigned NB = DW / 8;

   if (!hwpe_stream_is_pow2(NB_WORDS)) begin : g_bad_nb_words
      $error("hwpe_stream_tcdm_responder: NB_WORDS must be a power of 2");
   end
   if (DW != HWPE_STREAM_TCDM_DW) begin : g_bad_dw
      $error("hwpe_stream_tcdm_responder: DW must be 32");
   end
   if (LATENCY < 1 || LATENCY > HWPE_STREAM_TCDM_RESP_MAX_LATENCY) begin : g_bad_latency
      $error("hwpe_stream_tcdm_responder: LATENCY out of range 1..4");
   end

   logic              w_ctl_clr;
   logic              w_stall;
   logic              w_gnt;
   logic              w_acc;
   logic [AW-1:0]     w_idx;
   logic [DW-1:0]     w_rd_word;
   logic              w_unused;
   logic [DW-1:0]     r_mem [NB_WORDS];

   assign w_ctl_clr = rst_i | clear_i;
   assign w_gnt     = tcdm.req & ~w_stall & ~w_ctl_clr;
   assign w_acc     = w_gnt;
   // Byte offset and bits above the index are dropped: addresses alias modulo the array.
   assign w_idx     = tcdm.add[AW+1:2];
   assign w_unused  = ^tcdm.add;
   assign w_rd_word = tcdm.wen ? r_mem[w_idx] : '0;

   assign tcdm.gnt  = w_gnt;

   // Byte-enabled write into the array on an accepted write; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (w_acc && !tcdm.wen) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (tcdm.be[b]) begin
               r_mem[w_idx][8*b +: 8] <= tcdm.data[8*b +: 8];
            end
         end
      end
   end

   if (STALL_PERIOD == 0) begin : g_no_stall
      assign w_stall = 1'b0;
   end else begin : g_stall
      localparam int unsigned CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

      logic [CW-1:0] r_acc_cnt;
      logic          r_stall_q;

      // Count accepted txns mod STALL_PERIOD; the wrapping acceptance blocks the next cycle.
      always_ff @(posedge clk_i) begin
         if (rst_i || clear_i) begin
            r_acc_cnt <= '0;
            r_stall_q <= 1'b0;
         end else if (w_acc) begin
            if (r_acc_cnt == CW'(STALL_PERIOD - 1)) begin
               r_acc_cnt <= '0;
               r_stall_q <= 1'b1;
            end else begin
               r_acc_cnt <= r_acc_cnt + 1'b1;
               r_stall_q <= 1'b0;
            end
         end else begin
            r_stall_q <= 1'b0;
         end
      end

      assign w_stall = r_stall_q;
   end

   hwpe_stream_tcdm_resp_delay #(
      .LATENCY (LATENCY),
      .DW      (DW)
   ) i_delay (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .valid_i (w_acc),
      .data_i  (w_rd_word),
      .valid_o (tcdm.r_valid),
      .data_o  (tcdm.r_data),
      .busy_o  (busy_o)
   );

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Directed bench for hwpe_stream_tcdm_responder across four parameterisations.
module tb_hwpe_stream_tcdm_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic clr_d;
   logic busy_a, busy_b, busy_c, busy_d;

   hwpe_stream_tcdm_responder_if #(.DW(32)) ifa ();
   hwpe_stream_tcdm_responder_if #(.DW(32)) ifb ();
   hwpe_stream_tcdm_responder_if #(.DW(32)) ifc ();
   hwpe_stream_tcdm_responder_if #(.DW(32)) ifd ();

   hwpe_stream_tcdm_responder #(.NB_WORDS(1024), .DW(32), .LATENCY(1), .STALL_PERIOD(0)) dut_a (
      .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .tcdm(ifa), .busy_o(busy_a));
   hwpe_stream_tcdm_responder #(.NB_WORDS(1024), .DW(32), .LATENCY(3), .STALL_PERIOD(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .tcdm(ifb), .busy_o(busy_b));
   hwpe_stream_tcdm_responder #(.NB_WORDS(1024), .DW(32), .LATENCY(1), .STALL_PERIOD(4)) dut_c (
      .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .tcdm(ifc), .busy_o(busy_c));
   hwpe_stream_tcdm_responder #(.NB_WORDS(1024), .DW(32), .LATENCY(4), .STALL_PERIOD(0)) dut_d (
      .clk_i(clk), .rst_i(rst), .clear_i(clr_d), .tcdm(ifd), .busy_o(busy_d));

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Drive one txn on DUT A at posedge+1, check grant and the previous response at negedge.
   task automatic a_issue(input logic wen, input logic [31:0] add, input logic [3:0] be,
                          input logic [31:0] d, input logic pv, input logic [31:0] pd);
      ifa.req = 1'b1; ifa.wen = wen; ifa.add = add; ifa.be = be; ifa.data = d;
      @(negedge clk);
      chk("a_gnt", 32'(ifa.gnt), 32'd1);
      chk("a_prev_rvalid", 32'(ifa.r_valid), 32'(pv));
      if (pv) chk("a_prev_rdata", ifa.r_data, pd);
      @(posedge clk); #1;
      ifa.req = 1'b0;
   endtask

   task automatic a_resp(input logic [31:0] d);
      @(negedge clk);
      chk("a_rvalid", 32'(ifa.r_valid), 32'd1);
      chk("a_rdata", ifa.r_data, d);
      chk("a_busy_resp", 32'(busy_a), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic a_idle();
      @(negedge clk);
      chk("a_idle_rvalid", 32'(ifa.r_valid), 32'd0);
      chk("a_idle_busy", 32'(busy_a), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] pat;
      int unsigned nrv, nacc;

      rst = 1'b1; clr_d = 1'b0;
      ifa.req = 1'b1; ifa.wen = 1'b1; ifa.add = '0; ifa.be = '0; ifa.data = '0;
      ifb.req = 1'b0; ifb.wen = 1'b1; ifb.add = '0; ifb.be = '0; ifb.data = '0;
      ifc.req = 1'b0; ifc.wen = 1'b1; ifc.add = '0; ifc.be = '0; ifc.data = '0;
      ifd.req = 1'b1; ifd.wen = 1'b1; ifd.add = '0; ifd.be = '0; ifd.data = '0;

      // Reset state, grant suppressed while reset is high even with req
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt_a", 32'(ifa.gnt), 32'd0);
      chk("rst_gnt_d", 32'(ifd.gnt), 32'd0);
      chk("rst_rvalid_a", 32'(ifa.r_valid), 32'd0);
      chk("rst_rdata_a", ifa.r_data, 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_rvalid_d", 32'(ifd.r_valid), 32'd0);
      chk("rst_busy_d", 32'(busy_d), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; ifa.req = 1'b0; ifd.req = 1'b0;

      // Write then read, LATENCY=1
      a_issue(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
      a_issue(1'b1, 32'h10, 4'h0, 32'h0,        1'b1, 32'h0);
      a_resp(32'hDEADBEEF);
      a_idle();

      // Byte enables, plus a be=0 write that must not change the word
      a_issue(1'b0, 32'h10, 4'hF,    32'h11223344, 1'b0, 32'h0);
      a_issue(1'b0, 32'h10, 4'b0101, 32'hAABBCCDD, 1'b1, 32'h0);
      a_issue(1'b0, 32'h13, 4'b0000, 32'hFFFFFFFF, 1'b1, 32'h0);
      a_issue(1'b1, 32'h10, 4'h0,    32'h0,        1'b1, 32'h0);
      a_resp(32'h11BB33DD);
      a_idle();

      // Address wrap and read-after-write in the next cycle
      a_issue(1'b0, 32'h0,    4'hF, 32'h5, 1'b0, 32'h0);
      a_issue(1'b1, 32'h1000, 4'h0, 32'h0, 1'b1, 32'h0);
      a_resp(32'h5);
      a_issue(1'b1, 32'h3002, 4'h0, 32'h0, 1'b0, 32'h0);
      a_resp(32'h5);
      a_idle();

      // LATENCY=3: fill words 0..7, then 8 back-to-back reads
      for (int unsigned cyc = 0; cyc < 8; cyc++) begin
         ifb.req = 1'b1; ifb.wen = 1'b0; ifb.add = 32'(cyc * 4); ifb.be = 4'hF; ifb.data = 32'h100 + 32'(cyc);
         @(negedge clk);
         chk("b_wr_gnt", 32'(ifb.gnt), 32'd1);
         @(posedge clk); #1;
      end
      ifb.req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int unsigned cyc = 0; cyc < 13; cyc++) begin
         ifb.req = (cyc < 8); ifb.wen = 1'b1; ifb.add = 32'(cyc * 4);
         @(negedge clk);
         if (cyc < 8) chk("b_rd_gnt", 32'(ifb.gnt), 32'd1);
         chk("b_rvalid", 32'(ifb.r_valid), 32'(cyc >= 3 && cyc <= 10));
         if (cyc >= 3 && cyc <= 10) chk("b_rdata", ifb.r_data, 32'h100 + 32'(cyc - 3));
         chk("b_busy", 32'(busy_b), 32'(cyc >= 1 && cyc <= 10));
         @(posedge clk); #1;
      end
      ifb.req = 1'b0;

      // STALL_PERIOD=4 with req held 12 cycles
      pat = 12'b1111_0_1111_0_11;
      nrv = 0; nacc = 0;
      for (int unsigned cyc = 0; cyc < 15; cyc++) begin
         ifc.req = (cyc < 12); ifc.wen = 1'b0; ifc.be = 4'hF; ifc.add = 32'(cyc * 4); ifc.data = 32'(cyc);
         @(negedge clk);
         if (cyc < 12) chk("c_gnt", 32'(ifc.gnt), 32'(pat[11-cyc]));
         if (ifc.req && ifc.gnt) nacc++;
         if (ifc.r_valid) nrv++;
         @(posedge clk); #1;
      end
      chk("c_accepted", nacc, 32'd10);
      chk("c_rvalid_cnt", nrv, 32'd10);
      // Counter now at 2: two more grants wrap it; the stall is consumed without req
      ifc.req = 1'b1;
      @(negedge clk); chk("c_gnt_w0", 32'(ifc.gnt), 32'd1);
      @(posedge clk); #1;
      @(negedge clk); chk("c_gnt_w1", 32'(ifc.gnt), 32'd1);
      @(posedge clk); #1;
      ifc.req = 1'b0;
      @(posedge clk); #1;
      ifc.req = 1'b1;
      @(negedge clk); chk("c_gnt_after_idle_stall", 32'(ifc.gnt), 32'd1);
      @(posedge clk); #1;
      ifc.req = 1'b0;

      // LATENCY=4: store a word, then clear with two reads in flight
      ifd.req = 1'b1; ifd.wen = 1'b0; ifd.add = 32'h20; ifd.be = 4'hF; ifd.data = 32'hCAFEF00D;
      @(negedge clk); chk("d_wr_gnt", 32'(ifd.gnt), 32'd1);
      @(posedge clk); #1;
      ifd.req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("d_wr_rvalid", 32'(ifd.r_valid), 32'd1);
      chk("d_wr_rdata", ifd.r_data, 32'd0);
      @(posedge clk); #1;
      ifd.req = 1'b1; ifd.wen = 1'b1; ifd.add = 32'h20;
      @(negedge clk); chk("d_rd0_gnt", 32'(ifd.gnt), 32'd1);
      @(posedge clk); #1;
      @(negedge clk); chk("d_rd1_gnt", 32'(ifd.gnt), 32'd1);
      @(posedge clk); #1;
      clr_d = 1'b1;
      @(negedge clk);
      chk("d_clr_gnt", 32'(ifd.gnt), 32'd0);
      chk("d_clr_busy_before", 32'(busy_d), 32'd1);
      @(posedge clk); #1;
      clr_d = 1'b0; ifd.req = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("d_post_clr_rvalid", 32'(ifd.r_valid), 32'd0);
         chk("d_post_clr_busy", 32'(busy_d), 32'd0);
         if (k == 0) chk("d_post_clr_rdata", ifd.r_data, 32'd0);
         @(posedge clk); #1;
      end
      ifd.req = 1'b1; ifd.wen = 1'b1; ifd.add = 32'h20;
      @(negedge clk); chk("d_rd2_gnt", 32'(ifd.gnt), 32'd1);
      @(posedge clk); #1;
      ifd.req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("d_rd2_rvalid", 32'(ifd.r_valid), 32'd1);
      chk("d_rd2_rdata", ifd.r_data, 32'hCAFEF00D);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
